// File: rtl/serial_mag_compare.sv
// Bit-serial MSB-first magnitude comparator: one bit pair per valid cycle, gt/lt/eq reported with a done pulse.
// Optional macro SIGNED_CMP_EN: treat operands as two's complement (MSB pair compares with inverted sense).
module serial_mag_compare #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic gt,
    output logic lt,
    output logic eq
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          gt_reg, gt_next;
    logic          lt_reg, lt_next;
    logic          eq_reg, eq_next;
    logic          decided_reg, decided_next;
    logic          a_wins, b_wins;

`ifdef SIGNED_CMP_EN
    // The sign bit carries negative weight, so a set MSB makes the operand smaller.
    logic msb_phase;
    assign msb_phase = (cnt_reg == '0);
    assign a_wins    = msb_phase ? b_bit : a_bit;
    assign b_wins    = msb_phase ? a_bit : b_bit;
`else
    assign a_wins = a_bit;
    assign b_wins = b_bit;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            gt_reg      <= 1'b0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            decided_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            gt_reg      <= gt_next;
            lt_reg      <= lt_next;
            eq_reg      <= eq_next;
            decided_reg <= decided_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        gt_next      = gt_reg;
        lt_next      = lt_reg;
        eq_next      = eq_reg;
        decided_next = decided_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = COMPARE;
                    cnt_next     = '0;
                    gt_next      = 1'b0;
                    lt_next      = 1'b0;
                    eq_next      = 1'b0;
                    decided_next = 1'b0;
                end
            end
            COMPARE: begin
                if (bit_valid) begin
                    if (!decided_reg && (a_bit != b_bit)) begin
                        gt_next      = a_wins;
                        lt_next      = b_wins;
                        decided_next = 1'b1;
                    end
                    // Counter parks on the last index rather than wrapping to zero.
                    if (cnt_reg == LAST_IDX) begin
                        state_next = DONE;
                        eq_next    = ~gt_next & ~lt_next;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign gt   = gt_reg;
    assign lt   = lt_reg;
    assign eq   = eq_reg;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare (W=8): expected results queued at start, checked on done.
module tb_serial_mag_compare;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic busy, done, gt, lt, eq;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int done_expected = 0;
    logic [2:0] exp_q[$];

    serial_mag_compare #(.W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .bit_valid(bit_valid),
        .a_bit(a_bit),
        .b_bit(b_bit),
        .busy(busy),
        .done(done),
        .gt(gt),
        .lt(lt),
        .eq(eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef SIGNED_CMP_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        if ($signed(a) < $signed(b)) return 3'b010;
`else
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
`endif
        return 3'b001;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("result_gtlteq", {29'd0, gt, lt, eq}, {29'd0, e});
                $display("done: gt=%0b lt=%0b eq=%0b expected=%03b", gt, lt, eq, e);
            end
        end
    end

    // restart_at: pulse start while driving that bit index (0 = MSB); abort_at: reset after that many bits.
    task automatic compare(input logic [7:0] a, input logic [7:0] b, input int gap,
                           input int restart_at, input int abort_at);
        logic [2:0] e;
        e = model(a, b);
        if (abort_at < 0) begin
            exp_q.push_back(e);
            done_expected++;
        end
        $display("cmp: a=%02h b=%02h gap=%0d restart=%0d abort=%0d", a, b, gap, restart_at, abort_at);
        @(negedge clk);
        start = 1'b1;
        bit_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bit_valid = 1'b1;
            a_bit = a[7-k];
            b_bit = b[7-k];
            if (k == restart_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            bit_valid = 1'b0;
            a_bit = ~a_bit;
            b_bit = ~b_bit;
            if (k + 1 == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                check("abort_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
                repeat (12) @(negedge clk);
                check("abort_idle", {31'd0, busy}, 32'd0);
                return;
            end
            if (k < 7) begin
                repeat (gap) begin
                    check("busy_stall", {31'd0, busy}, 32'd1);
                    @(negedge clk);
                end
                check("busy_bit", {31'd0, busy}, 32'd1);
            end
        end
        check("done_latency", {30'd0, done, busy}, 32'd3);
        @(negedge clk);
        check("done_pulse", {30'd0, done, busy}, 32'd0);
        check("result_hold", {29'd0, gt, lt, eq}, {29'd0, e});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {27'd0, busy, done, gt, lt, eq}, 32'd0);

        compare(8'hA5, 8'h5A, 0, -1, -1);
        compare(8'h3C, 8'h3C, 0, -1, -1);
        compare(8'h80, 8'h7F, 0, -1, -1);
        compare(8'h12, 8'h13, 3, -1, -1);
        compare(8'hC3, 8'h42, 0, 4, -1);
        compare(8'h55, 8'h54, 0, -1, 5);
        compare(8'h01, 8'h00, 0, -1, -1);
        compare(8'h7F, 8'hFF, 1, -1, -1);
        compare(8'h00, 8'h00, 0, -1, -1);
        compare(8'hFF, 8'hFE, 0, -1, -1);
        for (int r = 0; r < 6; r++) begin
            compare(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), r % 3, -1, -1);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("done_count", done_seen, done_expected);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
